// File: rtl/cc_cond_unit.sv
// cc_cond_unit
// ----------------------------------------------------------------------------
// Execute-stage consumer of the ALU condition code. Holds the architectural
// CC register and evaluates jXX/cmovXX conditions against the stored flags.
// It also registers Cnd, the branch-mispredict flag and valid into the E->M
// pipeline boundary, under stall/bubble control.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   e_valid      E stage holds a real instruction (0 = bubble)
//   e_set_cc     E instruction is an OPq; load CC from the ALU
//   e_is_jxx     E instruction is a conditional jump
//   e_is_cmov    E instruction is a cmovXX/rrmovq
//   e_ifun       condition selector
//   alu_cc       flags produced by the ALU this cycle
//   m_exc        instruction in M has an exception
//   w_exc        instruction in W has an exception
//   m_stall      hold the E->M register
//   m_bubble     load the E->M register with a bubble
//   cc_q         current architectural CC (ZF=0, SF=1, OF=2, CF=3)
//   e_cnd        combinational condition result for the E instruction
//   m_cnd        registered Cnd, E->M
//   m_mispredict registered: jXX predicted taken but not taken
//   m_valid      registered valid, E->M
// ----------------------------------------------------------------------------
module cc_cond_unit #(
    parameter int              CC_W   = 4,
    parameter int              IFUN_W = 4,
    parameter logic [CC_W-1:0] CC_RST = 4'b0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e_valid,
    input  logic              e_set_cc,
    input  logic              e_is_jxx,
    input  logic              e_is_cmov,
    input  logic [IFUN_W-1:0] e_ifun,
    input  logic [CC_W-1:0]   alu_cc,
    input  logic              m_exc,
    input  logic              w_exc,
    input  logic              m_stall,
    input  logic              m_bubble,
    output logic [CC_W-1:0]   cc_q,
    output logic              e_cnd,
    output logic              m_cnd,
    output logic              m_mispredict,
    output logic              m_valid
);

    localparam int ZF_BIT = 0;
    localparam int SF_BIT = 1;
    localparam int OF_BIT = 2;
    localparam int CF_BIT = 3;

    localparam logic [IFUN_W-1:0] C_ALWAYS = IFUN_W'(0);
    localparam logic [IFUN_W-1:0] C_LE     = IFUN_W'(1);
    localparam logic [IFUN_W-1:0] C_L      = IFUN_W'(2);
    localparam logic [IFUN_W-1:0] C_E      = IFUN_W'(3);
    localparam logic [IFUN_W-1:0] C_NE     = IFUN_W'(4);
    localparam logic [IFUN_W-1:0] C_GE     = IFUN_W'(5);
    localparam logic [IFUN_W-1:0] C_G      = IFUN_W'(6);
    localparam logic [IFUN_W-1:0] C_B      = IFUN_W'(7);
    localparam logic [IFUN_W-1:0] C_AE     = IFUN_W'(8);
    localparam logic [IFUN_W-1:0] C_A      = IFUN_W'(9);
    localparam logic [IFUN_W-1:0] C_BE     = IFUN_W'(10);

    logic zf;
    logic sf;
    logic of;
    logic cf;
    logic sxo;
    logic cond_raw;
    logic cc_load;
    logic mispredict_d;

    assign zf  = cc_q[ZF_BIT];
    assign sf  = cc_q[SF_BIT];
    assign of  = cc_q[OF_BIT];
    assign cf  = cc_q[CF_BIT];
    assign sxo = sf ^ of;

    // Decode the selected condition against the stored flags only. The ALU
    // flags of the current cycle are deliberately not looked at: an OPq
    // followed by a jXX sees the OPq result one cycle later through cc_q,
    // so no forwarding path is needed. Unused selectors evaluate false.
    always_comb begin
        cond_raw = 1'b0;
        case (e_ifun)
            C_ALWAYS: cond_raw = 1'b1;
            C_LE:     cond_raw = sxo | zf;
            C_L:      cond_raw = sxo;
            C_E:      cond_raw = zf;
            C_NE:     cond_raw = ~zf;
            C_GE:     cond_raw = ~sxo;
            C_G:      cond_raw = ~sxo & ~zf;
            C_B:      cond_raw = cf;
            C_AE:     cond_raw = ~cf;
            C_A:      cond_raw = ~cf & ~zf;
            C_BE:     cond_raw = cf | zf;
            default:  cond_raw = 1'b0;
        endcase
    end

    // Cnd is only meaningful for a real jXX or cmov. When both type bits are
    // set the instruction is treated as a jXX, which only matters for the
    // mispredict flag since the condition itself is shared.
    assign e_cnd        = e_valid & (e_is_jxx | e_is_cmov) & cond_raw;
    assign mispredict_d = e_valid & e_is_jxx & ~e_cnd;

    // An exception further down the pipe means the E instruction is younger
    // and must not change architectural state. A stall also blocks the load
    // so the same OPq is not half-committed. A bubble into M does not block
    // it: the E instruction still executes.
    assign cc_load = e_valid & e_set_cc & ~m_exc & ~w_exc & ~m_stall;

    // Architectural condition-code register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= CC_RST;
        end else if (cc_load) begin
            cc_q <= alu_cc;
        end
    end

    // E->M pipeline register. Stall has priority over bubble so that a stall
    // and a bubble requested together keep the current contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid      <= 1'b0;
            m_cnd        <= 1'b0;
            m_mispredict <= 1'b0;
        end else if (m_stall) begin
            m_valid      <= m_valid;
            m_cnd        <= m_cnd;
            m_mispredict <= m_mispredict;
        end else if (m_bubble) begin
            m_valid      <= 1'b0;
            m_cnd        <= 1'b0;
            m_mispredict <= 1'b0;
        end else begin
            m_valid      <= e_valid;
            m_cnd        <= e_cnd;
            m_mispredict <= mispredict_d;
        end
    end

endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit
// ----------------------------------------------------------------------------
// Self-checking bench for cc_cond_unit. A table of {flags, selector, expected
// Cnd} records covers the condition decode, hand-written sequences cover the
// exception, stall, bubble and asynchronous-reset corner cases, and a random
// phase compares every cycle against a small behavioural model of the flags
// and the E->M register.
// ----------------------------------------------------------------------------
module tb_cc_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       e_valid;
    logic       e_set_cc;
    logic       e_is_jxx;
    logic       e_is_cmov;
    logic [3:0] e_ifun;
    logic [3:0] alu_cc;
    logic       m_exc;
    logic       w_exc;
    logic       m_stall;
    logic       m_bubble;
    logic [3:0] cc_q;
    logic       e_cnd;
    logic       m_cnd;
    logic       m_mispredict;
    logic       m_valid;

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [3:0] mdlCc;
    logic       mdlValid;
    logic       mdlCnd;
    logic       mdlMis;

    typedef struct {
        logic [3:0] cc;
        logic [3:0] ifun;
        logic       exp;
    } vec_t;

    vec_t table_v[$];

    always #5 clk = ~clk;

    cc_cond_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .e_valid      (e_valid),
        .e_set_cc     (e_set_cc),
        .e_is_jxx     (e_is_jxx),
        .e_is_cmov    (e_is_cmov),
        .e_ifun       (e_ifun),
        .alu_cc       (alu_cc),
        .m_exc        (m_exc),
        .w_exc        (w_exc),
        .m_stall      (m_stall),
        .m_bubble     (m_bubble),
        .cc_q         (cc_q),
        .e_cnd        (e_cnd),
        .m_cnd        (m_cnd),
        .m_mispredict (m_mispredict),
        .m_valid      (m_valid)
    );

    // Condition evaluated from the named flags as comparison outcomes:
    // "signed less" is SF differing from OF, "unsigned below" is the carry.
    function automatic logic condOf(input logic [3:0] cc, input logic [3:0] ifun);
        logic zero, below, lessSigned;
        zero       = cc[0];
        lessSigned = (cc[1] != cc[2]);
        below      = cc[3];
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return lessSigned || zero;
            4'd2:    return lessSigned;
            4'd3:    return zero;
            4'd4:    return !zero;
            4'd5:    return !lessSigned;
            4'd6:    return !lessSigned && !zero;
            4'd7:    return below;
            4'd8:    return !below;
            4'd9:    return !below && !zero;
            4'd10:   return below || zero;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Drive one cycle's inputs shortly after a rising edge and let them settle.
    task automatic applyStimulus(input logic v, input logic setcc, input logic jxx,
                                 input logic cmov, input logic [3:0] ifun,
                                 input logic [3:0] alu, input logic mexc,
                                 input logic wexc, input logic stall,
                                 input logic bubble);
        e_valid   = v;
        e_set_cc  = setcc;
        e_is_jxx  = jxx;
        e_is_cmov = cmov;
        e_ifun    = ifun;
        alu_cc    = alu;
        m_exc     = mexc;
        w_exc     = wexc;
        m_stall   = stall;
        m_bubble  = bubble;
        #1;
    endtask

    // Check e_cnd against the model, clock once, advance the model and check
    // every registered output.
    task automatic stepCheck(input string tag);
        logic expCnd;
        expCnd = e_valid && (e_is_jxx || e_is_cmov) && condOf(mdlCc, e_ifun);
        checkOutput({tag, ".e_cnd"}, {3'b0, e_cnd}, {3'b0, expCnd});
        if (e_valid && e_set_cc && !m_exc && !w_exc && !m_stall) mdlCc = alu_cc;
        if (!m_stall) begin
            if (m_bubble) begin
                mdlValid = 1'b0;
                mdlCnd   = 1'b0;
                mdlMis   = 1'b0;
            end else begin
                mdlValid = e_valid;
                mdlCnd   = expCnd;
                mdlMis   = e_valid && e_is_jxx && !expCnd;
            end
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".cc_q"}, cc_q, mdlCc);
        checkOutput({tag, ".m_valid"}, {3'b0, m_valid}, {3'b0, mdlValid});
        checkOutput({tag, ".m_cnd"}, {3'b0, m_cnd}, {3'b0, mdlCnd});
        checkOutput({tag, ".m_mispredict"}, {3'b0, m_mispredict}, {3'b0, mdlMis});
    endtask

    task automatic modelReset();
        mdlCc    = 4'b0001;
        mdlValid = 1'b0;
        mdlCnd   = 1'b0;
        mdlMis   = 1'b0;
    endtask

    initial begin
        // Hand-derived decode table
        table_v.push_back('{4'b0001, 4'd0,  1'b1});
        table_v.push_back('{4'b0001, 4'd1,  1'b1});
        table_v.push_back('{4'b0001, 4'd3,  1'b1});
        table_v.push_back('{4'b0001, 4'd4,  1'b0});
        table_v.push_back('{4'b0001, 4'd6,  1'b0});
        table_v.push_back('{4'b0001, 4'd10, 1'b1});
        table_v.push_back('{4'b0110, 4'd2,  1'b0});
        table_v.push_back('{4'b0110, 4'd5,  1'b1});
        table_v.push_back('{4'b0110, 4'd6,  1'b1});
        table_v.push_back('{4'b0110, 4'd1,  1'b0});
        table_v.push_back('{4'b0010, 4'd2,  1'b1});
        table_v.push_back('{4'b0010, 4'd5,  1'b0});
        table_v.push_back('{4'b0010, 4'd1,  1'b1});
        table_v.push_back('{4'b0010, 4'd6,  1'b0});
        table_v.push_back('{4'b1000, 4'd7,  1'b1});
        table_v.push_back('{4'b1000, 4'd8,  1'b0});
        table_v.push_back('{4'b1000, 4'd9,  1'b0});
        table_v.push_back('{4'b1000, 4'd10, 1'b1});
        table_v.push_back('{4'b0000, 4'd9,  1'b1});
        table_v.push_back('{4'b0000, 4'd7,  1'b0});
        table_v.push_back('{4'b0000, 4'd11, 1'b0});
        table_v.push_back('{4'b0000, 4'd15, 1'b0});
        table_v.push_back('{4'b0100, 4'd0,  1'b1});

        // Reset state
        rst_n = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0);
        #10;
        checkOutput("rst.cc_q", cc_q, 4'b0001);
        checkOutput("rst.m_valid", {3'b0, m_valid}, 4'd0);
        checkOutput("rst.m_cnd", {3'b0, m_cnd}, 4'd0);
        checkOutput("rst.m_mispredict", {3'b0, m_mispredict}, 4'd0);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // jXX e on the reset flags: taken, no mispredict
        applyStimulus(1, 0, 1, 0, 4'd3, 4'd0, 0, 0, 0, 0);
        checkOutput("p1.e_cnd", {3'b0, e_cnd}, 4'd1);
        stepCheck("p1");
        checkOutput("p1.m_cnd_fix", {3'b0, m_cnd}, 4'd1);
        checkOutput("p1.mis_fix", {3'b0, m_mispredict}, 4'd0);

        // OPq SF,OF then jl (not taken -> mispredict), then jge
        applyStimulus(1, 1, 0, 0, 4'd0, 4'b0110, 0, 0, 0, 0);
        stepCheck("p2.opq");
        applyStimulus(1, 0, 1, 0, 4'd2, 4'd0, 0, 0, 0, 0);
        checkOutput("p2.jl", {3'b0, e_cnd}, 4'd0);
        stepCheck("p2.jl");
        checkOutput("p2.mis_fix", {3'b0, m_mispredict}, 4'd1);
        applyStimulus(1, 0, 1, 0, 4'd5, 4'd0, 0, 0, 0, 0);
        checkOutput("p2.jge", {3'b0, e_cnd}, 4'd1);
        stepCheck("p2.jge");

        // Exceptions suppress the CC load
        applyStimulus(1, 1, 0, 0, 4'd0, 4'b1000, 1, 0, 0, 0);
        stepCheck("p3.mexc");
        checkOutput("p3.hold_fix", cc_q, 4'b0110);
        applyStimulus(1, 1, 0, 0, 4'd0, 4'b1000, 0, 1, 0, 0);
        stepCheck("p3.wexc");
        applyStimulus(1, 1, 0, 0, 4'd0, 4'b1000, 0, 0, 0, 0);
        stepCheck("p3.load");
        checkOutput("p3.load_fix", cc_q, 4'b1000);
        applyStimulus(1, 0, 1, 0, 4'd7, 4'd0, 0, 0, 0, 0);
        checkOutput("p3.jb", {3'b0, e_cnd}, 4'd1);
        stepCheck("p3.jb");
        applyStimulus(1, 0, 0, 1, 4'd9, 4'd0, 0, 0, 0, 0);
        checkOutput("p3.cmova", {3'b0, e_cnd}, 4'd0);
        stepCheck("p3.cmova");

        // Stall for two cycles while e_cnd toggles and an OPq is presented
        applyStimulus(1, 0, 1, 0, 4'd7, 4'd0, 0, 0, 0, 0);
        stepCheck("p4.pre");
        applyStimulus(1, 1, 1, 0, 4'd8, 4'b0001, 0, 0, 1, 0);
        stepCheck("p4.st1");
        applyStimulus(1, 1, 1, 0, 4'd7, 4'b0001, 0, 0, 1, 0);
        stepCheck("p4.st2");
        checkOutput("p4.cc_fix", cc_q, 4'b1000);
        checkOutput("p4.valid_fix", {3'b0, m_valid}, 4'd1);
        applyStimulus(1, 0, 1, 1, 4'd8, 4'd0, 0, 0, 1, 1);
        stepCheck("p4.stbub");
        checkOutput("p4.stbub_fix", {3'b0, m_valid}, 4'd1);

        // Bubble with a not-taken jXX still loads CC
        applyStimulus(1, 1, 1, 0, 4'd8, 4'b0101, 0, 0, 0, 1);
        stepCheck("p5.bub");
        checkOutput("p5.valid_fix", {3'b0, m_valid}, 4'd0);
        checkOutput("p5.mis_fix", {3'b0, m_mispredict}, 4'd0);
        checkOutput("p5.cc_fix", cc_q, 4'b0101);

        // Bubble in E never alters CC or produces a mispredict
        applyStimulus(0, 1, 1, 0, 4'd2, 4'b1111, 0, 0, 0, 0);
        stepCheck("p5.ebub");

        // Decode table
        foreach (table_v[i]) begin
            applyStimulus(1, 1, 0, 0, 4'd0, table_v[i].cc, 0, 0, 0, 0);
            stepCheck("tbl.load");
            applyStimulus(1, 0, 1, 0, table_v[i].ifun, 4'd0, 0, 0, 0, 0);
            checkOutput($sformatf("tbl[%0d]", i), {3'b0, e_cnd}, {3'b0, table_v[i].exp});
            stepCheck("tbl.jxx");
        end

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            applyStimulus(($urandom_range(3) != 0), $urandom_range(1),
                          $urandom_range(1), $urandom_range(1),
                          4'($urandom_range(15)), 4'($urandom_range(15)),
                          ($urandom_range(9) == 0), ($urandom_range(9) == 0),
                          ($urandom_range(6) == 0), ($urandom_range(6) == 0));
            stepCheck("rnd");
        end

        // Asynchronous reset in the middle of a cycle
        applyStimulus(1, 1, 0, 1, 4'd0, 4'b1111, 0, 0, 0, 0);
        stepCheck("p6.set");
        checkOutput("p6.cc_set", cc_q, 4'b1111);
        checkOutput("p6.valid_set", {3'b0, m_valid}, 4'd1);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("p6.cc_q", cc_q, 4'b0001);
        checkOutput("p6.m_valid", {3'b0, m_valid}, 4'd0);
        checkOutput("p6.m_cnd", {3'b0, m_cnd}, 4'd0);
        checkOutput("p6.m_mispredict", {3'b0, m_mispredict}, 4'd0);
        applyStimulus(0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 1, 0, 4'd3, 4'd0, 0, 0, 0, 0);
        stepCheck("p6.after");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
